// File: rtl/mult_ctrl.sv
// Sequencing controller for the RV32M multiply ops around an unsigned wall_tree multiplier.
// Optional MULT_ZERO_FAST_EN: zero operands skip the tree and complete straight from accept.
module mult_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [31:0] tree_a,
  output logic [31:0] tree_b,
  input  logic [63:0] tree_f
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = 2 * XLEN;
  localparam int unsigned CW   = 4;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FIXUP  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [PW-1:0]   prod, prod_next, prod_fix;
  logic            neg, neg_next;
  logic [1:0]      op, op_next;
  logic [XLEN-1:0] tree_a_next, tree_b_next, resp_data_next;
  logic            resp_valid_next;
  logic            accept, rs1_neg, rs2_neg;
  logic [XLEN-1:0] rs1_mag, rs2_mag;
  logic            unused_funct3;

  assign unused_funct3 = funct3[2];
  assign req_ready     = (state == IDLE);
  assign accept        = req_valid & req_ready;

  // Only signed operands that are negative get folded to a magnitude
  assign rs1_neg  = ((funct3[1:0] == OP_MULH) || (funct3[1:0] == OP_MULHSU)) && rs1[XLEN-1];
  assign rs2_neg  = (funct3[1:0] == OP_MULH) && rs2[XLEN-1];
  assign rs1_mag  = rs1_neg ? (~rs1 + XLEN'(1)) : rs1;
  assign rs2_mag  = rs2_neg ? (~rs2 + XLEN'(1)) : rs2;
  assign prod_fix = neg ? (~prod + PW'(1)) : prod;

`ifdef MULT_ZERO_FAST_EN
  logic zero_op;
  assign zero_op = (rs1 == '0) || (rs2 == '0);
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      prod       <= '0;
      neg        <= 1'b0;
      op         <= OP_MUL;
      tree_a     <= '0;
      tree_b     <= '0;
      resp_data  <= '0;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      prod       <= prod_next;
      neg        <= neg_next;
      op         <= op_next;
      tree_a     <= tree_a_next;
      tree_b     <= tree_b_next;
      resp_data  <= resp_data_next;
      resp_valid <= resp_valid_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef MULT_ZERO_FAST_EN
          state_next = zero_op ? DONE : SETTLE;
`else
          state_next = SETTLE;
`endif
        end
      end
      SETTLE:  if (cnt == '0) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      DONE:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and response next values
  always_comb begin
    cnt_next        = cnt;
    prod_next       = prod;
    neg_next        = neg;
    op_next         = op;
    tree_a_next     = tree_a;
    tree_b_next     = tree_b;
    resp_data_next  = resp_data;
    resp_valid_next = (state_next == DONE);
    case (state)
      IDLE: begin
        if (accept) begin
          tree_a_next = rs1_mag;
          tree_b_next = rs2_mag;
          neg_next    = rs1_neg ^ rs2_neg;
          op_next     = funct3[1:0];
          cnt_next    = CW'(SETTLE_CYCLES - 1);
`ifdef MULT_ZERO_FAST_EN
          if (zero_op) resp_data_next = '0;
`endif
        end
      end
      SETTLE: begin
        if (cnt != '0) cnt_next = cnt - CW'(1);
        else           prod_next = tree_f;
      end
      FIXUP: begin
        resp_data_next = (op == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl: vector table of RV32M cases plus backpressure and reset sequences.
`timescale 1ns/1ps
module tb_mult_ctrl;

  localparam int unsigned S   = 4;
  localparam int          LAT = S + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [31:0] tree_a, tree_b;
  logic [63:0] tree_f;

  int n_cmp = 0;
  int n_err = 0;

  mult_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .tree_a     (tree_a),
    .tree_b     (tree_b),
    .tree_f     (tree_f)
  );

  // Unsigned multiplier standing in for wall_tree
  assign tree_f = 64'(tree_a) * 64'(tree_b);

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_d;
    logic [31:0] exp_ta;
    logic [31:0] exp_tb;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_ZERO_FAST_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return LAT;
  endfunction

  // Called just after a negedge; returns at the negedge of cycle 1 after accept
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    int w;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({name, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    funct3    = f;
    rs1       = a;
    rs2       = b;
    @(negedge clk);
    req_valid = 1'b0;
    funct3    = 3'($urandom);
    rs1       = $urandom;
    rs2       = $urandom;
  endtask

  // Returns the cycle index (after accept) in which resp_valid is first seen high
  task automatic wait_resp(input string name, output int lat);
    bit busy_ok;
    busy_ok = 1'b1;
    lat = 1;
    while (!resp_valid && lat < 60) begin
      if (req_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (req_ready) busy_ok = 1'b0;
    check({name, "_busy"}, 64'(busy_ok), 64'd1);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic [31:0] exp_ta,
                        input logic [31:0] exp_tb, input string name);
    int lat;
    issue(f, a, b, name);
    check({name, "_tree_a"}, 64'(tree_a), 64'(exp_ta));
    check({name, "_tree_b"}, 64'(tree_b), 64'(exp_tb));
    wait_resp(name, lat);
    check({name, "_lat"}, 64'(lat), 64'(exp_lat(a, b)));
    check({name, "_data"}, 64'(resp_data), 64'(exp_d));
    @(negedge clk);
    check({name, "_taken"}, 64'({resp_valid, req_ready}), 64'b01);
    check({name, "_hold"}, 64'(resp_data), 64'(exp_d));
  endtask

  initial begin
    int lat;
    vecs[0]  = '{3'b000, 32'd5,        32'd6,        32'h0000001E, 32'd5,        32'd6};
    vecs[1]  = '{3'b000, 32'hFFFFFFFB, 32'd6,        32'hFFFFFFE2, 32'hFFFFFFFB, 32'd6};
    vecs[2]  = '{3'b001, 32'hFFFFFFFB, 32'd6,        32'hFFFFFFFF, 32'd5,        32'd6};
    vecs[3]  = '{3'b011, 32'hFFFFFFFB, 32'd6,        32'h00000005, 32'hFFFFFFFB, 32'd6};
    vecs[4]  = '{3'b010, 32'hFFFFFFFB, 32'd6,        32'hFFFFFFFF, 32'd5,        32'd6};
    vecs[5]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h80000000, 32'h80000000};
    vecs[6]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[7]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF};
    vecs[8]  = '{3'b000, 32'd7,        32'd3,        32'd21,       32'd7,        32'd3};
    vecs[9]  = '{3'b000, 32'd0,        32'h12345678, 32'd0,        32'd0,        32'h12345678};
    vecs[10] = '{3'b001, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7,        32'd1};
    vecs[11] = '{3'b100, 32'd3,        32'd4,        32'd12,       32'd3,        32'd4};
    vecs[12] = '{3'b011, 32'h80000000, 32'd2,        32'd1,        32'h80000000, 32'd2};

    rst        = 1'b0;
    req_valid  = 1'b0;
    funct3     = 3'd0;
    rs1        = 32'd0;
    rs2        = 32'd0;
    resp_ready = 1'b1;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready",  64'(req_ready),  64'd1);
    check("rst_valid",  64'(resp_valid), 64'd0);
    check("rst_data",   64'(resp_data),  64'd0);
    check("rst_tree_a", 64'(tree_a),     64'd0);
    check("rst_tree_b", 64'(tree_b),     64'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_ta, vecs[i].exp_tb,
             $sformatf("v%0d", i));
    end

    // Backpressure: DONE holds while resp_ready is low, requests ignored
    resp_ready = 1'b0;
    issue(3'b000, 32'd9, 32'd9, "bp");
    wait_resp("bp", lat);
    check("bp_lat",  64'(lat),       64'(LAT));
    check("bp_data", 64'(resp_data), 64'd81);
    for (int i = 0; i < 10; i++) begin
      req_valid = ((i % 2) == 0);
      funct3    = 3'($urandom);
      rs1       = $urandom;
      rs2       = $urandom;
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), 64'({resp_valid, req_ready, resp_data}),
            64'({1'b1, 1'b0, 32'd81}));
    end
    req_valid = 1'b0;
    check("bp_tree_a", 64'(tree_a), 64'd9);
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 64'({resp_valid, req_ready}), 64'b01);
    run_op(3'b000, 32'd2, 32'd3, 32'd6, 32'd2, 32'd3, "bp_next");

    // Asynchronous reset in the middle of SETTLE
    issue(3'b001, 32'hFFFFFFFB, 32'd6, "ar");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("ar_ready",  64'(req_ready),  64'd1);
    check("ar_valid",  64'(resp_valid), 64'd0);
    check("ar_data",   64'(resp_data),  64'd0);
    check("ar_tree_a", 64'(tree_a),     64'd0);
    check("ar_tree_b", 64'(tree_b),     64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'b000, 32'd7, 32'd3, 32'd21, 32'd7, 32'd3, "ar_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
